// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: link between the game controller and the scroll/scoring stage
interface game_state_ctrl_if;
  logic        hit;
  logic        missed;
  logic [22:0] diff;
  logic        play_en;
  logic        game_clr;
  modport master (input hit, missed, output diff, play_en, game_clr);
  modport slave (output hit, missed, input diff, play_en, game_clr);
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: start sync, game FSM, lives/streak/level bookkeeping and difficulty select
module game_state_ctrl #(
  parameter int MAX_LIVES      = 3,
  parameter int HITS_PER_LEVEL = 16,
  parameter int SONG_HITS      = 64,
  parameter int COUNTDOWN_CYC  = 10_000_000,
  parameter int DIFF_L0        = 6_000_000,
  parameter int DIFF_L1        = 4_500_000,
  parameter int DIFF_L2        = 3_000_000,
  parameter int DIFF_L3        = 1_500_000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  game_state_ctrl_if.master gi,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic [7:0] streak,
  output logic [7:0] best_streak,
  output logic [1:0] level,
  output logic       win,
  output logic       lose
);
  typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, WIN = 3'd3, LOSE = 3'd4} state_t;
  localparam logic [31:0] CD_LAST = 32'(COUNTDOWN_CYC - 1);
  localparam logic [31:0] HPL     = 32'(HITS_PER_LEVEL);
  localparam logic [7:0]  SONG    = 8'(SONG_HITS);
  localparam logic [2:0]  LIVES0  = 3'(MAX_LIVES);
  state_t      st;
  logic        s0, s1, s2, v0, armed, start_evt, clr;
  logic [2:0]  lives_r, lives_nxt;
  logic [7:0]  streak_r, streak_nxt, best_r, hit_cnt, hit_nxt;
  logic [1:0]  level_r, lvl_nxt;
  logic [31:0] cd_cnt, lvl_q;
  // armed only after start is seen low post-reset, so a button held through reset is not a press
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) {s0, s1, s2, v0, armed} <= '0;
    else begin
      s0    <= start;
      s1    <= s0;
      s2    <= s1;
      v0    <= 1'b1;
      armed <= armed | (v0 & ~s0);
    end
  assign start_evt = s1 & ~s2 & armed;
  always_comb begin
    hit_nxt    = hit_cnt + 8'(gi.hit && hit_cnt != 8'hff);
    streak_nxt = gi.missed ? 8'd0 : streak_r + 8'(gi.hit && streak_r != 8'hff);
    lives_nxt  = lives_r - 3'(gi.missed && lives_r != 3'd0);
    lvl_q      = 32'(hit_nxt) / HPL;
    lvl_nxt    = lvl_q > 32'd3 ? 2'd3 : lvl_q[1:0];
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      st       <= IDLE;
      lives_r  <= '0;
      streak_r <= '0;
      best_r   <= '0;
      level_r  <= '0;
      hit_cnt  <= '0;
      clr      <= 1'b0;
      cd_cnt   <= '0;
    end else begin
      clr <= 1'b0;
      case (st)
        IDLE: if (start_evt) begin
          st       <= COUNTDOWN;
          clr      <= 1'b1;
          lives_r  <= LIVES0;
          streak_r <= '0;
          hit_cnt  <= '0;
          level_r  <= '0;
          cd_cnt   <= '0;
        end
        COUNTDOWN: begin
          cd_cnt <= cd_cnt + 32'd1;
          if (cd_cnt == CD_LAST) st <= PLAY;
        end
        PLAY: begin
          hit_cnt  <= hit_nxt;
          streak_r <= streak_nxt;
          lives_r  <= lives_nxt;
          level_r  <= lvl_nxt;
          if (streak_nxt > best_r) best_r <= streak_nxt;
          // losing the last life takes priority over completing the song
          if (lives_nxt == 3'd0) st <= LOSE;
          else if (gi.hit && hit_nxt == SONG) st <= WIN;
        end
        WIN, LOSE: if (start_evt) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  assign state       = st;
  assign lives       = lives_r;
  assign streak      = streak_r;
  assign best_streak = best_r;
  assign level       = level_r;
  assign win         = st == WIN;
  assign lose        = st == LOSE;
  assign gi.play_en  = st == PLAY;
  assign gi.game_clr = clr;
  assign gi.diff     = level_r == 2'd0 ? 23'(DIFF_L0) :
                       level_r == 2'd1 ? 23'(DIFF_L1) :
                       level_r == 2'd2 ? 23'(DIFF_L2) : 23'(DIFF_L3);
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed checks of game_state_ctrl (main game plus a short-song instance)
module tb_game_state_ctrl;
  logic clk = 1'b0, n_rst, start;
  logic [2:0] state_a, lives_a, state_b, lives_b;
  logic [7:0] streak_a, best_a, streak_b, best_b;
  logic [1:0] level_a, level_b;
  logic win_a, lose_a, win_b, lose_b;
  int n_run = 0, n_fail = 0, clr_cnt = 0, clr_saved;
  game_state_ctrl_if ia();
  game_state_ctrl_if ib();
  game_state_ctrl #(.COUNTDOWN_CYC(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .gi(ia), .state(state_a), .lives(lives_a),
    .streak(streak_a), .best_streak(best_a), .level(level_a), .win(win_a), .lose(lose_a));
  game_state_ctrl #(.COUNTDOWN_CYC(8), .SONG_HITS(4), .MAX_LIVES(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start), .gi(ib), .state(state_b), .lives(lives_b),
    .streak(streak_b), .best_streak(best_b), .level(level_b), .win(win_b), .lose(lose_b));
  always #5 clk = ~clk;
  always @(negedge clk) if (ia.game_clr) clr_cnt++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    n_rst = 1'b0; start = 1'b0;
    ia.hit = 1'b0; ia.missed = 1'b0; ib.hit = 1'b0; ib.missed = 1'b0;
    step(2);
    check("rst_state", 32'(state_a), 0);
    check("rst_lives", 32'(lives_a), 0);
    check("rst_diff", 32'(ia.diff), 6000000);
    check("rst_best", 32'(best_a), 0);
    check("rst_clr", 32'(ia.game_clr), 0);
    n_rst = 1'b1;
    step(4);
    ia.hit = 1'b1; step(1); ia.hit = 1'b0; step(1);
    check("idle_hit_streak", 32'(streak_a), 0);
    check("idle_hit_state", 32'(state_a), 0);
    check("idle_hit_level", 32'(level_a), 0);
    start = 1'b1;
    step(3);
    check("cd_state", 32'(state_a), 1);
    check("cd_clr", 32'(ia.game_clr), 1);
    check("cd_lives", 32'(lives_a), 3);
    check("cd_state_b", 32'(state_b), 1);
    ia.hit = 1'b1; ia.missed = 1'b1; step(2); ia.hit = 1'b0; ia.missed = 1'b0;
    check("cd_clr_off", 32'(ia.game_clr), 0);
    check("cd_ignore_lives", 32'(lives_a), 3);
    step(5);
    check("cd_last_state", 32'(state_a), 1);
    step(1);
    check("play_state", 32'(state_a), 2);
    check("play_lives", 32'(lives_a), 3);
    check("play_diff", 32'(ia.diff), 6000000);
    check("play_en", 32'(ia.play_en), 1);
    check("play_streak", 32'(streak_a), 0);
    check("play_level", 32'(level_a), 0);
    step(89);
    check("held_start_state", 32'(state_a), 2);
    check("held_start_clrs", 32'(clr_cnt), 1);
    start = 1'b0;
    step(3);
    for (int i = 0; i < 16; i++) begin
      ia.hit = 1'b1; step(1); ia.hit = 1'b0; step(1);
      if (i == 14) check("lvl_15hits", 32'(level_a), 0);
    end
    check("lvl_16hits", 32'(level_a), 1);
    check("diff_16hits", 32'(ia.diff), 4500000);
    check("streak_16hits", 32'(streak_a), 16);
    check("best_16hits", 32'(best_a), 16);
    ia.missed = 1'b1; step(1); ia.missed = 1'b0;
    check("miss_streak", 32'(streak_a), 0);
    check("miss_lives", 32'(lives_a), 2);
    check("miss_best", 32'(best_a), 16);
    check("miss_state", 32'(state_a), 2);
    for (int i = 0; i < 2; i++) begin
      ia.missed = 1'b1; step(1); ia.missed = 1'b0; step(1);
    end
    check("lose_state", 32'(state_a), 4);
    check("lose_lives", 32'(lives_a), 0);
    check("lose_flag", 32'(lose_a), 1);
    check("lose_play_en", 32'(ia.play_en), 0);
    ia.hit = 1'b1; ia.missed = 1'b1; step(2); ia.hit = 1'b0; ia.missed = 1'b0;
    check("post_lose_lives", 32'(lives_a), 0);
    check("post_lose_streak", 32'(streak_a), 0);
    check("post_lose_level", 32'(level_a), 1);
    check("post_lose_state", 32'(state_a), 4);
    start = 1'b1; step(3); start = 1'b0;
    check("back_idle", 32'(state_a), 0);
    check("idle_hold_level", 32'(level_a), 1);
    step(4);
    start = 1'b1; step(3); start = 1'b0;
    check("cd2_state", 32'(state_a), 1);
    check("cd2_lives", 32'(lives_a), 3);
    check("cd2_level", 32'(level_a), 0);
    check("cd2_best", 32'(best_a), 16);
    step(8);
    check("play2_state", 32'(state_a), 2);
    for (int i = 0; i < 3; i++) begin
      ia.missed = 1'b1; step(1); ia.missed = 1'b0;
      check("miss_seq_lives", 32'(lives_a), 32'(2 - i));
      check("miss_seq_state", 32'(state_a), i == 2 ? 4 : 2);
      step(1);
    end
    for (int i = 0; i < 3; i++) begin
      ib.hit = 1'b1; step(1); ib.hit = 1'b0; step(1);
    end
    check("b_streak3", 32'(streak_b), 3);
    check("b_state_play", 32'(state_b), 2);
    ib.hit = 1'b1; ib.missed = 1'b1; step(1); ib.hit = 1'b0; ib.missed = 1'b0;
    check("b_both_state", 32'(state_b), 4);
    check("b_both_lose", 32'(lose_b), 1);
    check("b_both_win", 32'(win_b), 0);
    check("b_both_lives", 32'(lives_b), 0);
    check("b_both_streak", 32'(streak_b), 0);
    start = 1'b1; step(3); start = 1'b0; step(4);
    start = 1'b1; step(3); start = 1'b0;
    step(8);
    for (int i = 0; i < 2; i++) begin
      ia.hit = 1'b1; step(1); ia.hit = 1'b0; step(1);
    end
    check("mid_play_state", 32'(state_a), 2);
    check("mid_play_streak", 32'(streak_a), 2);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_state", 32'(state_a), 0);
    check("async_rst_lives", 32'(lives_a), 0);
    check("async_rst_streak", 32'(streak_a), 0);
    check("async_rst_best", 32'(best_a), 0);
    check("async_rst_level", 32'(level_a), 0);
    check("async_rst_diff", 32'(ia.diff), 6000000);
    check("async_rst_play_en", 32'(ia.play_en), 0);
    check("async_rst_best_b", 32'(best_b), 0);
    clr_saved = clr_cnt;
    start = 1'b1;
    #1 n_rst = 1'b1;
    step(10);
    check("held_rst_state", 32'(state_a), 0);
    check("held_rst_clrs", 32'(clr_cnt), 32'(clr_saved));
    start = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter MAX_LIVES, default 3, lives granted per game (1..7).
REQ-002 SHALL have parameter HITS_PER_LEVEL, default 16, hits needed to advance one difficulty level.
REQ-003 SHALL have parameter SONG_HITS, default 64, hits needed to win (1..255).
REQ-004 SHALL have parameter COUNTDOWN_CYC, default 10_000_000, number of clk cycles spent in COUNTDOWN.
REQ-005 SHALL have parameters DIFF_L0..DIFF_L3, defaults 6_000_000, 4_500_000, 3_000_000, 1_500_000, 23-bit scroll divider limit per level.
REQ-006 clk  input  1  system clock; all state updates on the rising edge.
REQ-007 n_rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  raw, asynchronous start pushbutton, active-high.
REQ-009 hit  input  1  single-cycle good-hit pulse from the scoring stage.
REQ-010 missed  input  1  single-cycle miss pulse from the scoring stage.
REQ-011 diff  output  23  scroll divider limit for the game stage.
REQ-012 play_en  output  1  high only in PLAY.
REQ-013 game_clr  output  1  single-cycle pulse that clears the downstream score counters.
REQ-014 state  output  3  encoded FSM state.
REQ-015 lives  output  3  remaining lives.
REQ-016 streak  output  8  current consecutive-hit count.
REQ-017 best_streak  output  8  largest streak since reset.
REQ-018 level  output  2  current difficulty level.
REQ-019 win  output  1  high in WIN.
REQ-020 lose  output  1  high in LOSE.

Function
REQ-021 start SHALL pass through a 2-flop synchronizer and a rising-edge detector; one press SHALL produce exactly one start_evt, 3 cycles after the raw edge at most.
REQ-022 States SHALL be encoded IDLE=0, COUNTDOWN=1, PLAY=2, WIN=3, LOSE=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-023 IDLE -> COUNTDOWN on start_evt; game_clr SHALL pulse in that same transition cycle (registered, visible the cycle after start_evt).
REQ-024 On entering COUNTDOWN: lives=MAX_LIVES, streak=0, hit_cnt=0, level=0, countdown counter=0.
REQ-025 COUNTDOWN -> PLAY after exactly COUNTDOWN_CYC cycles in COUNTDOWN; start_evt, hit and missed SHALL be ignored in COUNTDOWN.
REQ-026 In PLAY: on hit, hit_cnt +1 (saturates at 255) and streak +1 (saturates at 255); best_streak SHALL update to the new streak in the same cycle it is exceeded.
REQ-027 In PLAY: on missed, lives -1 (no underflow below 0) and streak=0.
REQ-028 On hit and missed in the same cycle: hit_cnt +1, lives -1, streak=0.
REQ-029 level SHALL equal min(hit_cnt / HITS_PER_LEVEL, 3), registered; diff SHALL be DIFF_Ln for the current level.
REQ-030 PLAY -> LOSE on the cycle lives reaches 0; PLAY -> WIN on the cycle hit_cnt reaches SONG_HITS; if both occur in the same cycle, LOSE SHALL win.
REQ-031 hit and missed SHALL be ignored outside PLAY; start_evt SHALL be ignored in PLAY.
REQ-032 WIN or LOSE -> IDLE on start_evt; lives, streak, level SHALL hold their final values until the next COUNTDOWN.
REQ-033 best_streak SHALL persist across games and clear only on reset.
REQ-034 play_en, win and lose SHALL be pure decodes of the registered state.

Reset
REQ-035 While n_rst=0, all flops SHALL clear immediately, independent of clk: state=IDLE, lives=0, streak=0, best_streak=0, level=0, hit_cnt=0, game_clr=0, and the synchronizer flops=0.
REQ-036 diff SHALL read DIFF_L0 during and after reset.
REQ-037 Reset asserted during any state, including mid-PLAY, SHALL abort to IDLE; a start held high through reset release SHALL NOT generate start_evt.

Verification
REQ-038 Reset, press start, COUNTDOWN_CYC=8 -> game_clr pulse once; state 1 for 8 cycles; then state=2, lives=3, diff=6_000_000.
REQ-039 In PLAY, 16 hit pulses -> level=1, diff=4_500_000, streak=16; one miss -> streak=0, lives=2, best_streak=16.
REQ-040 Three misses, no hits -> lives 3,2,1,0; state=4 on the cycle of the third miss; further pulses leave the counters unchanged.
REQ-041 SONG_HITS=4 with lives=1: fourth hit and a miss in the same cycle -> state=4 (LOSE), not WIN.
REQ-042 Hits during COUNTDOWN and IDLE -> no change to counters; start held high for 100 cycles -> exactly one start_evt.
REQ-043 n_rst pulsed low mid-PLAY between clk edges -> all outputs reset immediately; best_streak=0.
